data_bus_uart: RTL

DATA_BUS_UART -- requirements
Module: data_bus_uart

---
 rtl/data_bus_uart.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/data_bus_uart.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_uart
// Brief    : CPU data-bus slave with a word RAM and a FIFO-fed 8N1 UART TX.
// Revision : 1.0  initial release
// ============================================================================
module data_bus_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        uart_tx
);

  localparam int c_aw = $clog2(RAM_WORDS);
  localparam int c_pw = $clog2(FIFO_DEPTH);
  localparam int c_cw = $clog2(FIFO_DEPTH) + 1;
  localparam int c_bw = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0]     c_txdata_addr = 32'h0001_0000;
  localparam logic [31:0]     c_status_addr = 32'h0001_0004;
  localparam logic [c_cw-1:0] c_full_cnt    = c_cw'(FIFO_DEPTH);
  localparam logic [c_bw-1:0] c_cnt_last    = c_bw'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [31:0]     ram_q [RAM_WORDS];
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [c_pw-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_cw-1:0] count_q;
  logic            ovf_q;
  state_t          state_q, state_d;
  logic [c_bw-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic            w_ram_hit, w_txdata_hit, w_status_hit;
  logic [c_aw-1:0] w_ram_idx;
  logic            w_store;
  logic            w_fifo_empty, w_fifo_full, w_tx_busy;
  logic            w_pop, w_push_req, w_push, w_ovf_set, w_ovf_clr, w_cnt_last;

  assign w_ram_hit    = (addr[31:c_aw+2] == '0);
  assign w_txdata_hit = (addr == c_txdata_addr);
  assign w_status_hit = (addr == c_status_addr);
  assign w_ram_idx    = addr[c_aw+1:2];
  assign w_store      = mem_write && !reset;

  assign w_fifo_empty = (count_q == '0);
  assign w_fifo_full  = (count_q == c_full_cnt);
  assign w_tx_busy    = (state_q != S_IDLE);
  assign w_cnt_last   = (cnt_q == c_cnt_last);

  // A pop in the same cycle frees the slot, so a push to a full FIFO still fits.
  assign w_pop      = (state_q == S_IDLE) && !w_fifo_empty;
  assign w_push_req = w_store && w_txdata_hit;
  assign w_push     = w_push_req && (!w_fifo_full || w_pop);
  assign w_ovf_set  = w_push_req && w_fifo_full && !w_pop;
  assign w_ovf_clr  = w_store && w_status_hit && wdata[3];

  always_ff @(posedge clock) begin
    if (w_store && w_ram_hit) begin
      ram_q[w_ram_idx] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (w_ram_hit) begin
      rdata = ram_q[w_ram_idx];
    end else if (w_status_hit) begin
      rdata = {28'b0, ovf_q, w_fifo_empty, w_fifo_full, w_tx_busy};
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= wdata[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + 1'b1;
      end else if (w_pop && !w_push) begin
        count_q <= count_q - 1'b1;
      end
      if (w_ovf_set) begin
        ovf_q <= 1'b1;
      end else if (w_ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          shift_d = fifo_q[rd_ptr_q];
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line level follows the next state so the registered output lines up with it.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;

endmodule
`default_nettype wire
